// File: rtl/riscv_data_mem_resp.sv
`default_nettype none
// riscv_data_mem_resp: word-organised data RAM answering the core load/store port after a fixed wait.
// Optional RISCV_DMEM_ERR_EN adds mem_err_o, which flags out-of-range and illegal byte-enable requests.
module riscv_data_mem_resp #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_be_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wd_i,
  output logic [31:0] mem_rd_o,
  output logic        mem_ready_o
`ifdef RISCV_DMEM_ERR_EN
  ,
  output logic        mem_err_o
`endif
);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic             we_q;
  logic [IDX_W-1:0] idx_q;
  logic             in_range_q;
  logic [31:0]      mem [MEM_WORDS];

  logic [IDX_W-1:0] req_idx;
  logic             req_in_range;
  logic             accept;
  logic             wr_en;
  logic             be_ok;
  logic             rd_we;
  logic             rd_in_range;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_load;
  logic             unused_addr_lsb;

  assign req_idx         = mem_addr_i[IDX_W+1:2];
  assign req_in_range    = ({2'b00, mem_addr_i[31:2]} < 32'(MEM_WORDS));
  assign unused_addr_lsb = ^mem_addr_i[1:0];

`ifdef RISCV_DMEM_ERR_EN
  logic err_q;

  always_comb begin
    case (mem_be_i)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b1000, 4'b0011, 4'b1100, 4'b1111: be_ok = 1'b1;
      default:                            be_ok = 1'b0;
    endcase
  end

  assign mem_err_o = (state == RESP) && err_q;
`else
  assign be_ok = 1'b1;
`endif

  assign accept = (state == IDLE) && mem_req_i;
  assign wr_en  = accept && mem_we_i && req_in_range && be_ok;

  // Writes commit at the accept edge so a later reset cannot lose them.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int n = 0; n < 4; n++) begin
        if (mem_be_i[n]) mem[req_idx][8*n +: 8] <= mem_wd_i[8*n +: 8];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (mem_req_i) begin
          state_nxt = (LATENCY > 0) ? WAIT : RESP;
          cnt_nxt   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With zero latency RESP is entered at the accept edge, before the capture registers load.
  assign rd_we       = (state == IDLE) ? mem_we_i     : we_q;
  assign rd_idx      = (state == IDLE) ? req_idx      : idx_q;
  assign rd_in_range = (state == IDLE) ? req_in_range : in_range_q;
  assign rd_load     = (state != RESP) && (state_nxt == RESP) && !rd_we;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      we_q       <= 1'b0;
      idx_q      <= '0;
      in_range_q <= 1'b0;
      mem_rd_o   <= 32'h0;
`ifdef RISCV_DMEM_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        we_q       <= mem_we_i;
        idx_q      <= req_idx;
        in_range_q <= req_in_range;
`ifdef RISCV_DMEM_ERR_EN
        err_q      <= !req_in_range || !be_ok;
`endif
      end
      if (rd_load) mem_rd_o <= rd_in_range ? mem[rd_idx] : 32'h0;
    end
  end

  assign mem_ready_o = (state == RESP);

endmodule
`default_nettype wire

// File: doc/riscv_data_mem_resp.md
Name: riscv_data_mem_resp

Overview:
- Memory-side responder for the core load/store memory protocol: accepts req/we/be/addr/wd, returns read data, and pulses ready after a fixed, configurable wait.
- Holds a word-organised data RAM with per-byte write enables.
- Sits between the LSU memory port and the data address space. It is the bench and FPGA data memory for the single-cycle core.

Parameters:
- MEM_WORDS, 1024: depth of the data array in 32-bit words; power of two, minimum 4.
- LATENCY, 2: wait cycles between request accept and the ready pulse; legal range 0..15.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- mem_req_i  input  1  request valid; held stable by the initiator until ready is seen.
- mem_we_i  input  1  1 = write, 0 = read.
- mem_be_i  input  4  byte enables; bit n selects byte lane n (bits 8n+7:8n).
- mem_addr_i  input  32  byte address; bits [1:0] are ignored, lanes come from mem_be_i.
- mem_wd_i  input  32  write data, already lane-replicated by the initiator.
- mem_rd_o  output  32  read data, full word; the initiator extracts lanes.
- mem_ready_o  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_ni low, asynchronous): state=IDLE, mem_ready_o=0, mem_rd_o=32'h0, wait counter=0. Array contents are not cleared.
- Reset asserted mid-transaction aborts it. A write that was already accepted stays committed. No ready pulse is produced.
- Word index = mem_addr_i[IDX_W+1:2], where IDX_W = clog2(MEM_WORDS).
- In range: mem_addr_i[31:2] < MEM_WORDS.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If mem_req_i=1, accept at this edge and capture we/be/addr/wd.
  - Write: commit at the accept edge, only the lanes with be[n]=1.
  - be=4'b0000 is a legal no-op write.
  - Next state is WAIT if LATENCY>0, else RESP. The counter loads LATENCY-1.
- WAIT: the counter decrements each cycle. When it reaches 0, go to RESP on the next edge.
- On the edge entering RESP:
  - Read: mem_rd_o loads the array word at the captured index.
  - Write: mem_rd_o is unchanged.
- RESP: mem_ready_o=1 for exactly this cycle, then go to IDLE unconditionally.
- Latency: an accept at edge T gives mem_ready_o high in cycle T+1+LATENCY.
  - Example, LATENCY=2: ready is high in the 3rd cycle after the accept edge.
- mem_rd_o holds its last value outside RESP. It is only guaranteed meaningful while mem_ready_o=1 on a read.
- Back-to-back: after RESP the block is always in IDLE for at least one cycle.
  - mem_req_i still high in that IDLE cycle is a new request and is accepted.
  - Minimum issue interval is LATENCY+2 cycles.
- mem_req_i dropped during WAIT is a protocol violation. The captured request still completes and ready still pulses. Inputs in WAIT/RESP are ignored.
- Out-of-range address: the write is dropped, the read returns 32'h0, and ready still pulses with normal latency.
- Read and write never coincide, so there is no bypass path. A read issued after a write to the same word returns the updated word.

Optional Feature:
- Macro: RISCV_DMEM_ERR_EN.
- Defined:
  - Adds output mem_err_o (1 bit), reset 0.
  - mem_err_o is asserted together with mem_ready_o in RESP when the captured request is either out of range or has an illegal byte-enable pattern.
  - Legal be values: 0001, 0010, 0100, 1000, 0011, 1100, 1111, 0000.
  - Illegal-be write: the array is not modified.
  - Illegal-be read: returns the word normally.
- Undefined: the port is absent. All be patterns are legal and written as given. Out-of-range behaviour is silent as described above.

Test Plan:
- Reset value check: assert rst_ni=0 asynchronously mid-cycle -> mem_ready_o=0 and mem_rd_o=0 immediately.
- Word write then read, LATENCY=2:
  - Write addr=0x10, be=1111, wd=0xDEADBEEF -> ready high 3 cycles after accept.
  - Read addr=0x10 -> mem_rd_o=0xDEADBEEF with ready.
- Byte and halfword merge:
  - Preload word 0x20 = 0x11223344.
  - Write be=0100, wd=0xAAAAAAAA, then be=0011, wd=0x55665566.
  - Read 0x20 -> 0x11AA5566.
- Back-to-back reads with req held high, LATENCY=0:
  - Ready pulses every 2 cycles.
  - Reads of 0x0 / 0x4 return the preloaded values in order.
- Reset mid-WAIT:
  - Write 0x30 = 0x12345678, drop rst_ni during WAIT -> no ready pulse.
  - After release, read 0x30 -> 0x12345678.
- Out of range, MEM_WORDS=1024:
  - Write 0x1000 = 0xFFFFFFFF -> ready pulses, array word 0 unchanged.
  - Read 0x1000 -> 0x00000000.
  - With RISCV_DMEM_ERR_EN defined -> mem_err_o=1 with ready.
  - be=0110 write -> mem_err_o=1 and the word is unmodified.
